gbt_elink_tx_framer: RTL and testbench

Parametrised frame generator that produces one BITS_PER_ELINK-bit word per e-link per frame clock, to feed the per-link output serializers of the GBT e-link transmitter. It has more links and a configurable word width, and adds three functions:
- a link bring-up sequencer: serializer reset hold, wait for GBT TX ready, training pattern, then run;
- per-link masking;
- built-in test modes: idle, PRBS-7 and training, plus single-frame error injection.

It sits between the ALCT data path and the serializer layer, in the 40 MHz frame-clock domain.

---
 rtl/gbt_elink_tx_framer.sv | 172 +++++++++++++++++
 tb/tb_gbt_elink_tx_framer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gbt_elink_tx_framer.sv
// Frame generator for the GBT e-link transmitter: link bring-up sequencer,
// per-link masking, test-pattern modes and single-frame error injection.
module gbt_elink_tx_framer #(
  parameter int unsigned NUM_ELINKS     = 14,
  parameter int unsigned BITS_PER_ELINK = 8,
  parameter int unsigned HOLD_CYCLES    = 31,
  parameter int unsigned TRAIN_FRAMES   = 256,
  parameter logic [7:0]  IDLE_PATTERN   = 8'h55,
  parameter logic [7:0]  TRAIN_PATTERN  = 8'hF0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 pll_locked,
  input  logic                                 gbt_txrdy,
  input  logic [NUM_ELINKS*BITS_PER_ELINK-1:0] data_i,
  input  logic [NUM_ELINKS-1:0]                link_mask,
  input  logic [1:0]                           mode,
  input  logic                                 retrain,
  input  logic                                 err_inject,
  output logic [NUM_ELINKS*BITS_PER_ELINK-1:0] data_o,
  output logic                                 io_reset,
  output logic [1:0]                           state_o,
  output logic [15:0]                          frame_cnt
);

  localparam int unsigned W      = BITS_PER_ELINK;
  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned TrainW = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [TrainW-1:0] TrainLast = TrainW'(TRAIN_FRAMES - 1);
  localparam logic [W-1:0]      IdleWord  = IDLE_PATTERN[W-1:0];
  localparam logic [W-1:0]      TrainWord = TRAIN_PATTERN[W-1:0];

  typedef enum logic [1:0] {StHold = 2'd0, StWaitRdy = 2'd1, StTrain = 2'd2, StRun = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [TrainW-1:0]   train_cnt_q, train_cnt_d;
  logic                lock_meta_q, lock_s;
  logic                io_reset_q;
  logic [15:0]         frame_cnt_q;
  logic [NUM_ELINKS*W-1:0] frame_d, frame_q;
  logic [6:0]          lfsr_q [NUM_ELINKS];
  logic [6:0]          lfsr_d [NUM_ELINKS];
  logic                prbs_on;

  // x^7+x^6+1, W steps; first generated bit lands in the word MSB.
  function automatic logic [W-1:0] prbs_word(input logic [6:0] seed);
    logic [6:0] s;
    s = seed;
    prbs_word = '0;
    for (int b = int'(W) - 1; b >= 0; b--) begin
      prbs_word[b] = s[6] ^ s[5];
      s = {s[5:0], s[6] ^ s[5]};
    end
  endfunction

  function automatic logic [6:0] prbs_next(input logic [6:0] seed);
    logic [6:0] s;
    s = seed;
    for (int b = 0; b < int'(W); b++) begin
      s = {s[5:0], s[6] ^ s[5]};
    end
    prbs_next = s;
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s      <= lock_meta_q;
    end
  end

  // Bring-up sequencer next state; lock loss outranks TX-ready, which outranks retrain.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    train_cnt_d = train_cnt_q;
    if (!lock_s) begin
      state_d    = StHold;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) state_d = StWaitRdy;
          else                        hold_cnt_d = hold_cnt_q + 1'b1;
        end
        StWaitRdy: begin
          if (gbt_txrdy) begin
            state_d     = StTrain;
            train_cnt_d = '0;
          end
        end
        StTrain: begin
          if (!gbt_txrdy)                    state_d = StWaitRdy;
          else if (train_cnt_q == TrainLast) state_d = StRun;
          else                               train_cnt_d = train_cnt_q + 1'b1;
        end
        StRun: begin
          if (!gbt_txrdy) begin
            state_d = StWaitRdy;
          end else if (retrain) begin
            state_d     = StTrain;
            train_cnt_d = '0;
          end
        end
        default: state_d = StHold;
      endcase
    end
  end

  // Per-link word selection and LFSR advance; LFSRs reload outside RUN/PRBS.
  always_comb begin
    frame_d = '0;
    prbs_on = (state_q == StRun) && (mode == 2'd2);
    for (int k = 0; k < int'(NUM_ELINKS); k++) begin
      lfsr_d[k] = prbs_on ? prbs_next(lfsr_q[k]) : 7'h7F;
      unique case (state_q)
        StHold:    frame_d[k*W +: W] = '0;
        StWaitRdy: frame_d[k*W +: W] = IdleWord;
        StTrain:   frame_d[k*W +: W] = link_mask[k] ? TrainWord : IdleWord;
        StRun: begin
          if (!link_mask[k]) begin
            frame_d[k*W +: W] = IdleWord;
          end else begin
            unique case (mode)
              2'd0:    frame_d[k*W +: W] = data_i[k*W +: W];
              2'd1:    frame_d[k*W +: W] = IdleWord;
              2'd2:    frame_d[k*W +: W] = prbs_word(lfsr_q[k]);
              default: frame_d[k*W +: W] = TrainWord;
            endcase
          end
        end
        default: frame_d[k*W +: W] = '0;
      endcase
    end
    // Injection applies after masking so it is visible even on a masked link 0.
    if (state_q == StRun && err_inject) frame_d[0] = ~frame_d[0];
  end

  // State, counters, output frame and serializer reset registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      train_cnt_q <= '0;
      io_reset_q  <= 1'b1;
      frame_cnt_q <= '0;
      frame_q     <= '0;
      for (int k = 0; k < int'(NUM_ELINKS); k++) lfsr_q[k] <= 7'h7F;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      train_cnt_q <= train_cnt_d;
      io_reset_q  <= (state_d == StHold);
      frame_q     <= frame_d;
      for (int k = 0; k < int'(NUM_ELINKS); k++) lfsr_q[k] <= lfsr_d[k];
      if (state_q != StRun && state_d == StRun) frame_cnt_q <= '0;
      else if (state_q == StRun)                frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign data_o    = frame_q;
  assign io_reset  = io_reset_q;
  assign state_o   = state_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gbt_elink_tx_framer.sv
// Directed bench for gbt_elink_tx_framer: default 14x8 instance plus a 4x2 instance.
module tb_gbt_elink_tx_framer;

  logic         clock = 1'b0;
  logic         reset, pll_locked, gbt_txrdy, retrain, err_inject;
  logic [111:0] data_i, data_o;
  logic [13:0]  link_mask;
  logic [1:0]   mode, state_o;
  logic         io_reset;
  logic [15:0]  frame_cnt;

  logic         reset2, lock2, rdy2, retrain2, err2;
  logic [7:0]   data_i2, data_o2;
  logic [3:0]   mask2;
  logic [1:0]   mode2, state2;
  logic         io_reset2;
  logic [15:0]  fcnt2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gbt_elink_tx_framer dut (
    .clock      (clock),
    .reset      (reset),
    .pll_locked (pll_locked),
    .gbt_txrdy  (gbt_txrdy),
    .data_i     (data_i),
    .link_mask  (link_mask),
    .mode       (mode),
    .retrain    (retrain),
    .err_inject (err_inject),
    .data_o     (data_o),
    .io_reset   (io_reset),
    .state_o    (state_o),
    .frame_cnt  (frame_cnt)
  );

  gbt_elink_tx_framer #(
    .NUM_ELINKS     (4),
    .BITS_PER_ELINK (2)
  ) dut2 (
    .clock      (clock),
    .reset      (reset2),
    .pll_locked (lock2),
    .gbt_txrdy  (rdy2),
    .data_i     (data_i2),
    .link_mask  (mask2),
    .mode       (mode2),
    .retrain    (retrain2),
    .err_inject (err2),
    .data_o     (data_o2),
    .io_reset   (io_reset2),
    .state_o    (state2),
    .frame_cnt  (fcnt2)
  );

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (data_o !== 112'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    checks++; if (io_reset !== 1'b1) begin errors++; $display("FAIL reset_io got %b want 1", io_reset); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && io_reset === 1'b1; i++) begin
      n++;
      @(negedge clock);
    end
    checks++; if (n != 33) begin errors++; $display("FAIL hold_len got %0d want 33", n); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL hold_exit_state got %0d want 1", state_o); end
    checks++; if (data_o !== 112'd0) begin errors++; $display("FAIL hold_last_data got %h want 0", data_o); end
    @(negedge clock);
    checks++;
    if (data_o !== {14{8'h55}}) begin errors++; $display("FAIL wait_idle got %h want 55s", data_o); end
  endtask

  task automatic test_training();
    int n;
    gbt_txrdy = 1'b1;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (data_o === {14{8'hF0}}) n++;
      if (state_o === 2'd3) break;
    end
    checks++; if (n != 256) begin errors++; $display("FAIL train_len got %0d want 256", n); end
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL run_state got %0d want 3", state_o); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL run_fcnt0 got %0d want 0", frame_cnt); end
    @(negedge clock);
    checks++; if (data_o[31:24] !== 8'hA7) begin errors++; $display("FAIL link3 got %h want a7", data_o[31:24]); end
    checks++; if (data_o !== data_i) begin errors++; $display("FAIL pass_data got %h want %h", data_o, data_i); end
  endtask

  task automatic test_prbs_inject();
    mode = 2'd2;
    err_inject = 1'b1;
    @(negedge clock);
    err_inject = 1'b0;
    checks++; if (data_o[7:0] !== 8'h03) begin errors++; $display("FAIL inj_link0 got %h want 03", data_o[7:0]); end
    checks++;
    if (data_o[111:8] !== {13{8'h02}}) begin errors++; $display("FAIL prbs_f0 got %h want 02s", data_o[111:8]); end
    @(negedge clock);
    checks++; if (data_o !== {14{8'h0C}}) begin errors++; $display("FAIL prbs_f1 got %h want 0cs", data_o); end
    mode = 2'd0;
    @(negedge clock);
    checks++; if (data_o !== data_i) begin errors++; $display("FAIL mode0_back got %h want %h", data_o, data_i); end
    mode = 2'd2;
    @(negedge clock);
    checks++; if (data_o !== {14{8'h02}}) begin errors++; $display("FAIL prbs_rf0 got %h want 02s", data_o); end
    @(negedge clock);
    checks++; if (data_o !== {14{8'h0C}}) begin errors++; $display("FAIL prbs_rf1 got %h want 0cs", data_o); end
    mode = 2'd0;
  endtask

  task automatic test_mask();
    link_mask = 14'h3FFE;
    @(negedge clock);
    checks++;
    if (data_o !== {data_i[111:8], 8'h55}) begin
      errors++; $display("FAIL mask_data got %h want %h", data_o, {data_i[111:8], 8'h55});
    end
    mode = 2'd3;
    @(negedge clock);
    checks++;
    if (data_o !== {{13{8'hF0}}, 8'h55}) begin errors++; $display("FAIL mask_train got %h", data_o); end
    mode = 2'd1;
    err_inject = 1'b1;
    @(negedge clock);
    err_inject = 1'b0;
    checks++;
    if (data_o !== {{13{8'h55}}, 8'h54}) begin errors++; $display("FAIL mask_inj got %h want 55s/54", data_o); end
    @(negedge clock);
    checks++; if (data_o !== {14{8'h55}}) begin errors++; $display("FAIL idle_mode got %h want 55s", data_o); end
    link_mask = 14'h3FFF;
    mode = 2'd0;
  endtask

  task automatic test_retrain();
    int n;
    retrain = 1'b1;
    @(negedge clock);
    retrain = 1'b0;
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL retrain_state got %0d want 2", state_o); end
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      // A retrain pulse during TRAIN must not restart the count.
      retrain = (n == 100);
      @(negedge clock);
      if (state_o !== 2'd2) break;
      n++;
    end
    retrain = 1'b0;
    checks++; if (n != 256) begin errors++; $display("FAIL retrain_len got %0d want 256", n); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL re_fcnt0 got %0d want 0", frame_cnt); end
    repeat (5) @(negedge clock);
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL fcnt5 got %0d want 5", frame_cnt); end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL pre_loss got %0d want 3", state_o); end
    retrain = 1'b1;
    @(negedge clock);
    retrain = 1'b0;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL loss_state got %0d want 0", state_o); end
    checks++; if (io_reset !== 1'b1) begin errors++; $display("FAIL loss_io got %b want 1", io_reset); end
    @(negedge clock);
    pll_locked = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (state_o !== 2'd0) break;
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL rehold_len got %0d want 32", n); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL rehold_exit got %0d want 1", state_o); end
    checks++; if (io_reset !== 1'b0) begin errors++; $display("FAIL rehold_io got %b want 0", io_reset); end
  endtask

  task automatic test_txrdy_drop();
    repeat (10) @(negedge clock);
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL in_train got %0d want 2", state_o); end
    gbt_txrdy = 1'b0;
    @(negedge clock);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL drop_state got %0d want 1", state_o); end
    checks++; if (data_o !== {14{8'hF0}}) begin errors++; $display("FAIL drop_last got %h want f0s", data_o); end
    @(negedge clock);
    checks++; if (data_o !== {14{8'h55}}) begin errors++; $display("FAIL drop_idle got %h want 55s", data_o); end
  endtask

  task automatic test_generics();
    logic [1:0] exp_w [4];
    logic [1:0] e;
    bit         found;
    exp_w = '{2'd0, 2'd0, 2'd0, 2'd2};
    lock2 = 1'b1;
    rdy2  = 1'b1;
    mode2 = 2'd2;
    @(negedge clock);
    reset2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (state2 === 2'd3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL g_run_reach got %0d want 3", state2); end
    checks++; if (fcnt2 !== 16'd0) begin errors++; $display("FAIL g_fcnt0 got %0d want 0", fcnt2); end
    for (int f = 0; f < 4; f++) begin
      @(negedge clock);
      e = exp_w[f];
      checks++;
      if (data_o2 !== {4{e}}) begin
        errors++; $display("FAIL g_prbs%0d got %h want %h", f, data_o2, {4{e}});
      end
    end
    repeat (69996) @(negedge clock);
    checks++; if (fcnt2 !== 16'd4464) begin errors++; $display("FAIL g_wrap got %0d want 4464", fcnt2); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pll_locked = 1'b1; gbt_txrdy = 1'b0; retrain = 1'b0; err_inject = 1'b0;
    mode = 2'd0; link_mask = 14'h3FFF;
    for (int k = 0; k < 14; k++) data_i[k*8 +: 8] = 8'h10 + 8'(k);
    data_i[31:24] = 8'hA7;
    reset2 = 1'b1; lock2 = 1'b0; rdy2 = 1'b0; retrain2 = 1'b0; err2 = 1'b0;
    data_i2 = 8'hC3; mask2 = 4'hF; mode2 = 2'd0;
    test_reset();
    test_training();
    test_prbs_inject();
    test_mask();
    test_retrain();
    test_lock_loss();
    test_txrdy_drop();
    test_generics();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
